// File: rtl/rv32i_pkg.sv
// Shared RV32I front-end definitions: architectural widths, reset vector and
// the {pc, instr} entry carried from fetch toward IF/ID.
package rv32i_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;
  // Canonical NOP (addi x0, x0, 0) injected by IF/ID on flush.
  localparam logic [XLEN-1:0] NOP_INSTR    = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Instruction fetches are always word aligned; low address bits are dropped.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush for the fetch queue. Head data is read
// combinationally; an empty FIFO presents the most recently popped entry.
module fetch_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 64,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] hold_q;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full, empty;
  logic             do_push, do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // Flush wins over everything; a push into a full FIFO is only legal with a pop.
  assign do_pop  = pop_i && !flush_i && !empty;
  assign do_push = push_i && !flush_i && (!full || do_pop);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is reset on purpose: the head must read as zero out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      hold_q <= '0;
    end else begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
      if (do_pop)  hold_q          <= mem_q[rd_ptr_q];
    end
  end

  assign head_o  = empty ? hold_q : mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Credit accounting upstream must never let a live push find the FIFO full.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push_i && !flush_i && full && !do_pop))
    else $error("fetch_fifo overflow");

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues credit-limited word
// requests, buffers in-order responses and discards stale ones after redirect.
module if_fetch_queue
  import rv32i_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_VECTOR,
  parameter int              DEPTH    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]  resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   credit_used;
  logic             credit_avail;
  logic             req_fire;
  logic             resp_live;
  logic             push;
  logic             pop;
  fetch_entry_t     push_entry;
  fetch_entry_t     head_entry;

  // Queued plus in-flight words may never exceed the FIFO depth, so every
  // live response is guaranteed a slot.
  assign credit_used  = {1'b0, fifo_count} + {1'b0, outstanding_q};
  assign credit_avail = credit_used < (CNT_W + 1)'(DEPTH);

  assign imem_req_valid = !reset && !redirect && credit_avail;
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding belongs to a request from before reset.
  assign resp_live = imem_resp_valid && (outstanding_q != '0);

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q - CNT_W'(resp_live) + CNT_W'(req_fire);
    drop_cnt_d    = drop_cnt_q;
    push          = 1'b0;
    if (redirect) begin
      // Every request still in flight after this cycle returns a stale word.
      fetch_pc_d = word_align(redirect_pc);
      resp_pc_d  = word_align(redirect_pc);
      drop_cnt_d = outstanding_q - CNT_W'(resp_live);
    end else begin
      if (resp_live) begin
        if (drop_cnt_q != '0) begin
          drop_cnt_d = drop_cnt_q - CNT_W'(1);
        end else begin
          push      = 1'b1;
          resp_pc_d = resp_pc_q + XLEN'(INSTR_BYTES);
        end
      end
      if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(INSTR_BYTES);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  assign push_entry = '{pc: resp_pc_q, instr: imem_resp_data};
  assign pop        = out_valid && out_ready;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (redirect),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head_entry),
    .count_o     (fifo_count)
  );

  assign out_valid = (fifo_count != '0);
  assign out_pc    = head_entry.pc;
  assign out_instr = head_entry.instr;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: an in-bench queue model checked every
// cycle, plus literal expectations for each fetch scenario.
module tb_if_fetch_queue;
  import rv32i_pkg::*;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  if_fetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_instr       (out_instr)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ~a ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hxxxx_xxxx;
  endfunction

  // ---------------- memory model (1-cycle latency, optional hold) ----------
  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;
  pend_t       pend[$];
  int          cyc = 0;
  bit          mem_hold = 1'b0;
  logic [31:0] hs_log[$];
  logic [31:0] pop_pc[$];
  logic [31:0] pop_instr[$];

  initial forever begin
    @(negedge clk);
    #1;
    if (!reset && !mem_hold && pend.size() != 0 && pend[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
    end
  end

  // ---------------- reference model: a queue of {pc, instr} ---------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;
  ent_t        mq[$];
  logic [31:0] m_fpc = RESET_PC;
  logic [31:0] m_rpc = RESET_PC;
  int          m_out = 0;
  int          m_drop = 0;

  bit          s_ok = 1'b0;
  bit          s_redir, s_ready, s_rv, s_oready, s_req_v, s_out_v;
  logic [31:0] s_rpc, s_rdata, s_req_a, s_out_pc, s_out_instr;

  // Compare: inputs are settled by +2 after the falling edge.
  initial forever begin
    @(negedge clk);
    #2;
    if (!reset) begin
      bit exp_req;
      exp_req = !redirect && (mq.size() + m_out < DEPTH);
      check("req_valid", imem_req_valid, exp_req);
      if (exp_req) check("req_addr", imem_req_addr, m_fpc);
      check("out_valid", out_valid, mq.size() != 0);
      if (mq.size() != 0) begin
        check("out_pc", out_pc, mq[0].pc);
        check("out_instr", out_instr, mq[0].instr);
      end
      s_redir = redirect;        s_rpc = redirect_pc;
      s_ready = imem_req_ready;  s_rv = imem_resp_valid;
      s_rdata = imem_resp_data;  s_oready = out_ready;
      s_req_v = imem_req_valid;  s_req_a = imem_req_addr;
      s_out_v = out_valid;       s_out_pc = out_pc;
      s_out_instr = out_instr;
      s_ok = 1'b1;
    end
  end

  // Model and memory state advance on each clock edge; reset is asynchronous.
  initial forever begin
    @(posedge clk or posedge reset);
    if (clk) cyc++;
    if (reset) begin
      mq.delete();
      pend.delete();
      m_fpc = RESET_PC;
      m_rpc = RESET_PC;
      m_out = 0;
      m_drop = 0;
      s_ok = 1'b0;
    end else if (s_ok) begin
      bit exp_req, live;
      exp_req = !s_redir && (mq.size() + m_out < DEPTH);
      live    = s_rv && (m_out > 0);
      if (s_req_v && s_ready) begin
        pend.push_back('{addr: s_req_a, due: cyc});
        hs_log.push_back(s_req_a);
      end
      if (s_out_v && s_oready && !s_redir) begin
        pop_pc.push_back(s_out_pc);
        pop_instr.push_back(s_out_instr);
      end
      if (s_redir) begin
        mq.delete();
        if (live) m_out--;
        m_drop = m_out;
        m_fpc  = {s_rpc[31:2], 2'b00};
        m_rpc  = m_fpc;
      end else begin
        if (mq.size() != 0 && s_oready) void'(mq.pop_front());
        if (live) begin
          m_out--;
          if (m_drop > 0) m_drop--;
          else begin
            mq.push_back('{pc: m_rpc, instr: s_rdata});
            m_rpc += 32'd4;
          end
        end
        if (exp_req && s_ready) begin
          m_fpc += 32'd4;
          m_out++;
        end
      end
      s_ok = 1'b0;
    end
  end

  // ---------------- stimulus helpers ---------------------------------------
  task automatic do_reset(input bit rdy, input bit ordy, input bit hold);
    @(negedge clk);
    reset = 1'b1;
    redirect = 1'b0;
    imem_req_ready = rdy;
    out_ready = ordy;
    mem_hold = hold;
    #1;
    check("rst_req_valid", imem_req_valid, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_out_instr", out_instr, 32'h0);
    @(negedge clk);
    hs_log.delete();
    pop_pc.delete();
    pop_instr.delete();
    reset = 1'b0;
  endtask

  task automatic wait_pops(input int n, input int budget);
    for (int i = 0; i < budget && pop_pc.size() < n; i++) @(negedge clk);
    check("pop_count_reached", pop_pc.size() >= n, 1'b1);
  endtask

  initial begin
    int first;

    // Reset then streaming.
    do_reset(1'b1, 1'b1, 1'b0);
    first = 0;
    for (int i = 1; i <= 8 && first == 0; i++) begin
      @(negedge clk);
      #3;
      if (out_valid) first = i;
    end
    check("first_valid_latency", (first >= 2 && first <= 3), 1'b1);
    wait_pops(6, 40);
    check("stream_pc0", at(pop_pc, 0), 32'h0000_0000);
    check("stream_pc1", at(pop_pc, 1), 32'h0000_0004);
    check("stream_pc2", at(pop_pc, 2), 32'h0000_0008);
    check("stream_instr0", at(pop_instr, 0), 32'hECA8_6420);
    check("stream_instr2", at(pop_instr, 2), mem_word(32'h8));

    // Backpressure: the queue fills to DEPTH and fetch stalls.
    do_reset(1'b1, 1'b0, 1'b0);
    repeat (12) @(negedge clk);
    #3;
    check("bp_accepted", hs_log.size(), 4);
    check("bp_req_valid_full", imem_req_valid, 1'b0);
    check("bp_out_valid", out_valid, 1'b1);
    @(negedge clk);
    out_ready = 1'b1;
    wait_pops(5, 40);
    check("bp_pop0", at(pop_pc, 0), 32'h0);
    check("bp_pop1", at(pop_pc, 1), 32'h4);
    check("bp_pop2", at(pop_pc, 2), 32'h8);
    check("bp_pop3", at(pop_pc, 3), 32'hC);
    check("bp_resume_addr", at(hs_log, 4), 32'h10);

    // Redirect with two requests in flight: both responses are dropped.
    do_reset(1'b0, 1'b1, 1'b1);
    @(negedge clk); imem_req_ready = 1'b1;
    repeat (2) @(negedge clk);
    imem_req_ready = 1'b0;
    @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 32'h0000_0100;
    #3;
    check("redir_no_req", imem_req_valid, 1'b0);
    @(negedge clk);
    redirect = 1'b0;
    mem_hold = 1'b0;
    imem_req_ready = 1'b1;
    wait_pops(2, 40);
    check("redir2_hs_before", at(hs_log, 1), 32'h4);
    check("redir2_first_req", at(hs_log, 2), 32'h100);
    check("redir2_pop0", at(pop_pc, 0), 32'h100);
    check("redir2_pop1", at(pop_pc, 1), 32'h104);
    check("redir2_instr0", at(pop_instr, 0), mem_word(32'h100));

    // Redirect with a response arriving in the same cycle: nothing left to drop.
    do_reset(1'b0, 1'b1, 1'b1);
    @(negedge clk); imem_req_ready = 1'b1;
    @(negedge clk); imem_req_ready = 1'b0;
    @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 32'h0000_0200;
    mem_hold = 1'b0;
    @(negedge clk);
    redirect = 1'b0;
    imem_req_ready = 1'b1;
    wait_pops(2, 40);
    check("redir1_pop0", at(pop_pc, 0), 32'h200);
    check("redir1_instr0", at(pop_instr, 0), mem_word(32'h200));
    check("redir1_pop1", at(pop_pc, 1), 32'h204);

    // Misaligned redirect and address wrap.
    do_reset(1'b1, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    hs_log.delete();
    pop_pc.delete();
    pop_instr.delete();
    @(negedge clk);
    redirect = 1'b0;
    #3;
    check("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
    wait_pops(2, 40);
    check("wrap_hs0", at(hs_log, 0), 32'hFFFF_FFFC);
    check("wrap_pop0", at(pop_pc, 0), 32'hFFFF_FFFC);
    check("wrap_pop1", at(pop_pc, 1), 32'h0000_0000);

    // Asynchronous reset between clock edges with three entries queued.
    do_reset(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20 && mq.size() != 3; i++) begin
      @(negedge clk);
      #3;
    end
    check("areset_pre_count3", mq.size(), 3);
    check("areset_pre_valid", out_valid, 1'b1);
    reset = 1'b1;
    #1;
    check("areset_out_valid", out_valid, 1'b0);
    check("areset_req_valid", imem_req_valid, 1'b0);
    check("areset_out_pc", out_pc, 32'h0);
    @(negedge clk);
    hs_log.delete();
    pop_pc.delete();
    pop_instr.delete();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    check("areset_restart_addr", at(hs_log, 0), RESET_PC);
    check("areset_restart_next", at(hs_log, 1), RESET_PC + 32'd4);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
Instruction-fetch front end that sits directly upstream of if_id_pipeline_reg. It owns the fetch PC and issues sequential word requests to instruction memory over a valid/ready request channel, then buffers the in-order responses in a DEPTH-entry FIFO. It presents {pc, instr} pairs to IF/ID under a valid/ready handshake. On a branch or jump redirect it flushes the queue and discards stale in-flight responses.

Parameters:
RESET_PC, 32'h0000_0000, fetch PC loaded on reset
DEPTH, 4, instruction FIFO entries; power of two, minimum 2; also bounds outstanding requests

Ports:
clk  in  1  core clock
reset  in  1  asynchronous active-high reset
redirect  in  1  taken branch/jal/jalr from EX; flush and refetch
redirect_pc  in  32  new fetch address; bits[1:0] ignored (treated as 0)
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  32  word-aligned fetch address
imem_resp_valid  in  1  response data valid; in order; no backpressure
imem_resp_data  in  32  instruction word
out_valid  out  1  head entry valid toward IF/ID
out_ready  in  1  IF/ID can accept (driven by hazard_unit if_id_write)
out_pc  out  32  PC of head instruction
out_instr  out  32  head instruction

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, port name reset.
- Registers: fetch_pc, resp_pc (PC of next expected live response), FIFO (pc+instr) with wrap-around rd/wr pointers and count, outstanding (0..DEPTH), drop_cnt (0..DEPTH).
- Reset: fetch_pc=resp_pc=RESET_PC; count, outstanding, and drop_cnt are 0; pointers are 0; imem_req_valid=0; out_valid=0; out_pc=0 and out_instr=0 (head storage cleared).
- Request: imem_req_valid = !redirect && (count + outstanding < DEPTH); imem_req_addr = fetch_pc.
- A handshake occurs when valid && ready. On handshake: fetch_pc += 4 (wraps modulo 2^32) and outstanding += 1.
- Stability: once asserted without redirect, req_valid/addr hold until accepted. A pop only frees credit; a response moves credit from outstanding to count.
- Response handling: on each imem_resp_valid, outstanding -= 1.
  - If drop_cnt > 0: the response is discarded and drop_cnt -= 1.
  - Otherwise push {resp_pc, data} and set resp_pc += 4.
- Credit rule: a live response never finds the FIFO full. An assertion must flag overflow.
- Output: out_valid = (count != 0); out_pc/out_instr come from the head entry, combinationally. Pop on out_valid && out_ready.
- Push and pop in the same cycle leave count unchanged. With count == 0 and a push, the entry becomes visible the next cycle (1-cycle response-to-output latency, no bypass).
- Redirect (priority over everything):
  - FIFO is flushed: count=0, pointers reset, and no push or pop takes effect that cycle.
  - fetch_pc = resp_pc = {redirect_pc[31:2], 2'b00}.
  - drop_cnt_next = outstanding - resp_valid; outstanding_next = outstanding - resp_valid.
  - No request is issued in the redirect cycle; requests resume the next cycle at the new PC.
- Back-to-back redirects: each recomputes drop_cnt from the current outstanding count; the latest redirect_pc wins.
- Full: count == DEPTH forces imem_req_valid = 0. out_ready held low with a full queue stalls fetch indefinitely without data loss.
- Empty: out_valid = 0, and out_pc/out_instr hold their last head contents (don't-care for IF/ID).
- Reset mid-operation: all state returns to reset values immediately. Responses arriving after reset deasserts belong to the memory model's reset and are not counted.

Decomposition:
- Shared package (rv32i_pkg): XLEN = 32, INSTR_BYTES = 4, RESET_VECTOR constant, NOP_INSTR = 32'h0000_0013 (used by IF/ID on flush).
- Sub-module fetch_fifo (parameter DEPTH, WIDTH=64): sync FIFO with push/pop/flush, count, head data.
- if_fetch_queue holds the PC, credit, and drop logic.

Test Plan:
- Reset then streaming: memory always ready with 1-cycle response latency, out_ready=1 → requests at 0x0, 0x4, 0x8, ...; out_pc sequence 0x0, 0x4, 0x8 with matching instrs; first out_valid 3 cycles after reset release.
- Backpressure: out_ready=0 → exactly 4 entries accepted, then imem_req_valid=0 at count=4. Set out_ready=1 → pops 0x0..0xC in order, then fetch resumes at 0x10.
- Redirect with 2 outstanding: redirect=1, redirect_pc=0x100 while outstanding=2 → FIFO empties; the next 2 responses are dropped; the next out_pc is 0x100, then 0x104.
- Redirect with a simultaneous response: resp_valid=1 in the redirect cycle, outstanding=1 → that response is discarded; drop_cnt=0; the first output is the redirect_pc instruction.
- Misaligned redirect and wrap: redirect_pc=0xFFFF_FFFE → fetches 0xFFFF_FFFC, then 0x0000_0000.
- Async reset mid-stream: assert reset between clk edges with count=3 → out_valid and imem_req_valid drop immediately; after release, fetch restarts at RESET_PC.
